demux_stream: RTL

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshaking. One input stream is routed by a per-beat select to one of N output channels. Each output channel has a one-entry holding register so that a stalled channel does not block beats addressed to other channels. It sits between a single producer and N independent consumers in the datapath and supersedes the combinational 1-to-4 demux.

---
 rtl/demux_stream_if.sv | 36 +++
 rtl/demux_stream.sv | 81 ++++++++
 2 files changed

// File: rtl/demux_stream_if.sv
// Stream bundle for demux_stream: one input stream, N output channels and the sticky select-error flag.
// master = the demux itself, slave = producer/consumer side. DEMUX_BCAST_EN adds in_bcast.
interface demux_stream_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SELW = $clog2(N);

  logic            in_valid;
  logic            in_ready;
  logic [SELW-1:0] in_sel;
  logic [W-1:0]    in_data;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic [N*W-1:0]  out_data;
  logic            err_sel;
`ifdef DEMUX_BCAST_EN
  logic            in_bcast;
`endif

  modport master (
`ifdef DEMUX_BCAST_EN
    input  in_bcast,
`endif
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, err_sel
  );

  modport slave (
`ifdef DEMUX_BCAST_EN
    output in_bcast,
`endif
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, err_sel
  );
endinterface

// File: rtl/demux_stream.sv
// Registered 1-to-N valid/ready demultiplexer with a one-entry holding register per channel.
// Optional broadcast routing is enabled by defining DEMUX_BCAST_EN.
module demux_stream #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst,
  demux_stream_if.master bus
);
  localparam int SELW = $clog2(N);

  logic [N-1:0]        v_q, v_d;
  logic [N-1:0][W-1:0] d_q, d_d;
  logic                err_q, err_d;
  logic [N-1:0]        can_acc;
  logic [N-1:0]        push;
  logic [N-1:0]        pop;
  logic                sel_ok;
  logic                rdy;
  logic                bcast;

`ifdef DEMUX_BCAST_EN
  assign bcast = bus.in_bcast;
`else
  assign bcast = 1'b0;
`endif

  assign can_acc = ~v_q | bus.out_ready;
  assign pop     = v_q & bus.out_ready;

  // Out-of-range selects leave rdy at 1 so the beat is swallowed rather than stalling the producer.
  always_comb begin
    sel_ok = 1'b0;
    rdy    = 1'b1;
    push   = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.in_sel == SELW'(i)) begin
        sel_ok = 1'b1;
        rdy    = can_acc[i];
      end
    end
    if (bcast) begin
      rdy = &can_acc;
    end
    for (int i = 0; i < N; i++) begin
      push[i] = bus.in_valid && rdy && (bcast || (bus.in_sel == SELW'(i)));
    end
  end

  always_comb begin
    v_d   = v_q;
    d_d   = d_q;
    err_d = err_q | (bus.in_valid && !bcast && !sel_ok);
    for (int i = 0; i < N; i++) begin
      if (push[i]) begin
        v_d[i] = 1'b1;
        d_d[i] = bus.in_data;
      end else if (pop[i]) begin
        v_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      d_q   <= '0;
      err_q <= 1'b0;
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      err_q <= err_d;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = v_q;
  assign bus.out_data  = d_q;
  assign bus.err_sel   = err_q;
endmodule
